// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter letting two requesters share one single-port synchronous memory.
// Define MEM_ARB_LOCK_EN to add a_lock/b_lock owner locking for atomic read-modify-write.
module mem_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

`ifdef MEM_ARB_LOCK_EN
    input  logic              a_lock,
    input  logic              b_lock,
`endif

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_b_q;
    logic              sel_b_q;
    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;

    logic              elig_a;
    logic              elig_b;
    logic              grant_any;
    logic              grant_b;

`ifdef MEM_ARB_LOCK_EN
    logic owner_v_q;
    logic owner_b_q;
    logic win_lock;

    // While an owner is registered, the other requester is not eligible at all.
    assign elig_a   = a_req && !(owner_v_q && owner_b_q);
    assign elig_b   = b_req && !(owner_v_q && !owner_b_q);
    assign win_lock = grant_b ? b_lock : a_lock;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_v_q <= 1'b0;
            owner_b_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (grant_any) begin
                owner_v_q <= win_lock;
                owner_b_q <= grant_b;
            end else if (owner_v_q && (owner_b_q ? !(b_req || b_lock) : !(a_req || a_lock))) begin
                owner_v_q <= 1'b0;
            end
        end
    end
`else
    assign elig_a = a_req;
    assign elig_b = b_req;
`endif

    // On a tie the requester that did not win last time goes next.
    assign grant_b   = elig_b && (!elig_a || !last_b_q);
    assign grant_any = elig_a || elig_b;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_b_q    <= 1'b1;
            sel_b_q     <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking everywhere so each register samples pre-edge values.
            state_q    <= state_d;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            if (state_q == S_IDLE && grant_any) begin
                sel_b_q     <= grant_b;
                last_b_q    <= grant_b;
                cmd_we_q    <= grant_b ? b_we    : a_we;
                cmd_addr_q  <= grant_b ? b_addr  : a_addr;
                cmd_wdata_q <= grant_b ? b_wdata : a_wdata;
            end
            if (state_q == S_WAIT && !cmd_we_q) begin
                if (sel_b_q) begin
                    b_rdata_q  <= mem_rdata;
                    b_rvalid_q <= 1'b1;
                end else begin
                    a_rdata_q  <= mem_rdata;
                    a_rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign a_gnt     = (state_q == S_ISSUE) && !sel_b_q;
    assign b_gnt     = (state_q == S_ISSUE) && sel_b_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

    // Strobes are gated by rst_n so a reset landing on ISSUE never commits a write.
    assign mem_en    = (state_q == S_ISSUE) && rst_n;
    assign mem_we    = mem_en && cmd_we_q;
    assign mem_addr  = cmd_addr_q;
    assign mem_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a grant-order memory model; lock scenario builds only with MEM_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       a_req = 1'b0, a_we = 1'b0;
    logic [3:0] a_addr = '0;
    logic [7:0] a_wdata = '0;
    logic       a_gnt, a_rvalid;
    logic [7:0] a_rdata;

    logic       b_req = 1'b0, b_we = 1'b0;
    logic [3:0] b_addr = '0;
    logic [7:0] b_wdata = '0;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;

`ifdef MEM_ARB_LOCK_EN
    logic       a_lock = 1'b0, b_lock = 1'b0;
`endif

    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef MEM_ARB_LOCK_EN
        .a_lock(a_lock), .b_lock(b_lock),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous 16x8 memory with one-cycle read latency and a preload port.
    logic [7:0] mem [16];
    logic       ld_en = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Edge-sampled request view and cycle counter.
    int   cyc = 0;
    logic samp_a = 1'b0, samp_b = 1'b0, samp_rst = 1'b0;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        samp_a   <= a_req;
        samp_b   <= b_req;
        samp_rst <= rst_n;
    end

    // Grant model: after a grant the port is busy for two more cycles, then
    // requests seen at an edge are arbitrated round-robin (B counts as last after reset).
    bit   arb_chk_on = 1'b1;
    logic m_last_b = 1'b1;
    int   m_busy = 0;
    logic exp_ga, exp_gb;
    always @(negedge clk) begin
        exp_ga = 1'b0;
        exp_gb = 1'b0;
        if (!samp_rst) begin
            m_last_b = 1'b1;
            m_busy   = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (samp_a || samp_b) begin
            if (samp_a && samp_b) begin
                exp_ga = m_last_b;
                exp_gb = !m_last_b;
            end else begin
                exp_ga = samp_a;
                exp_gb = samp_b;
            end
            m_last_b = exp_gb;
            m_busy   = 2;
        end
        if (arb_chk_on && (exp_ga || exp_gb || a_gnt || b_gnt)) begin
            checks++;
            if (a_gnt !== exp_ga || b_gnt !== exp_gb) begin
                errors++;
                $display("FAIL grant_model cyc=%0d got a_gnt=%b b_gnt=%b expected %b %b",
                         cyc, a_gnt, b_gnt, exp_ga, exp_gb);
            end
        end
    end

    // Read-data scoreboard used during randomized traffic.
    bit         sb_on = 1'b0;
    logic [7:0] ref_mem [16];
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    logic [7:0] prev_ra, prev_rb;
    always @(negedge clk) begin
        if (sb_on) begin
            checks++;
            if (a_rvalid) begin
                if (exp_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_rvalid_unexpected cyc=%0d", cyc);
                end else if (a_rdata !== exp_a[0]) begin
                    errors++;
                    $display("FAIL a_rdata cyc=%0d got %h expected %h", cyc, a_rdata, exp_a[0]);
                end
                if (exp_a.size() != 0) void'(exp_a.pop_front());
            end else if (a_rdata !== prev_ra) begin
                errors++;
                $display("FAIL a_rdata_hold cyc=%0d got %h expected %h", cyc, a_rdata, prev_ra);
            end
            checks++;
            if (b_rvalid) begin
                if (exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_rvalid_unexpected cyc=%0d", cyc);
                end else if (b_rdata !== exp_b[0]) begin
                    errors++;
                    $display("FAIL b_rdata cyc=%0d got %h expected %h", cyc, b_rdata, exp_b[0]);
                end
                if (exp_b.size() != 0) void'(exp_b.pop_front());
            end else if (b_rdata !== prev_rb) begin
                errors++;
                $display("FAIL b_rdata_hold cyc=%0d got %h expected %h", cyc, b_rdata, prev_rb);
            end
        end
        prev_ra = a_rdata;
        prev_rb = b_rdata;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        a_lock = 1'b0;
        b_lock = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        arb_chk_on = 1'b1;
    endtask

    // Drives up to one access per requester; reports grant/rvalid cycles (-1 = never seen).
    task automatic run_pair(input bit da, input bit awe, input logic [3:0] aad, input logic [7:0] awd,
                            input bit db, input bit bwe, input logic [3:0] bad, input logic [7:0] bwd,
                            output int ga, output int gb, output int ra, output int rb,
                            output logic [7:0] rda, output logic [7:0] rdb, output int nrv);
        int last;
        ga = -1; gb = -1; ra = -1; rb = -1; rda = '0; rdb = '0; nrv = 0;
        a_req = da; a_we = awe; a_addr = aad; a_wdata = awd;
        b_req = db; b_we = bwe; b_addr = bad; b_wdata = bwd;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_gnt && ga < 0) begin ga = cyc; a_req = 1'b0; end
            if (b_gnt && gb < 0) begin gb = cyc; b_req = 1'b0; end
            if (a_rvalid) begin nrv++; if (ra < 0) begin ra = cyc; rda = a_rdata; end end
            if (b_rvalid) begin nrv++; if (rb < 0) begin rb = cyc; rdb = b_rdata; end end
            last = (ga > gb) ? ga : gb;
            if ((!da || ga >= 0) && (!db || gb >= 0) && cyc >= last + 3) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = 4'(i);
            ld_data = (i == 4) ? 8'h48 : 8'(8'h10 + i);
        end
        @(negedge clk);
        ld_en = 1'b0;
        checks++;
        if ({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b expected 000000",
                     {a_gnt, b_gnt, a_rvalid, b_rvalid, mem_en, mem_we});
        end
        checks++;
        if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata got a=%h b=%h expected 00 00", a_rdata, b_rdata);
        end
        checks++;
        if (mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_mem_bus got addr=%h wdata=%h expected 0 00", mem_addr, mem_wdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        int s, ga, gb, ra, rb, nrv;
        logic [7:0] rda, rdb;
        do_reset();
        s = cyc;
        run_pair(1, 0, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (ga != s + 1) begin errors++; $display("FAIL rd_gnt_cycle got %0d expected %0d", ga, s + 1); end
        checks++;
        if (ra != s + 3) begin errors++; $display("FAIL rd_rvalid_cycle got %0d expected %0d", ra, s + 3); end
        checks++;
        if (rda !== 8'h48) begin errors++; $display("FAIL rd_data got %h expected 48", rda); end
        checks++;
        if (nrv != 1) begin errors++; $display("FAIL rd_rvalid_pulses got %0d expected 1", nrv); end
        checks++;
        if (gb != -1 || rb != -1 || b_rdata !== 8'h00) begin
            errors++;
            $display("FAIL rd_b_quiet got gnt=%0d rv=%0d rdata=%h expected -1 -1 00", gb, rb, b_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int s, ga, gb, ra, rb, nrv;
        logic [7:0] rda, rdb;
        do_reset();
        s = cyc;
        run_pair(1, 0, 4'd0, 8'h00, 1, 1, 4'd5, 8'hAA, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (ga != s + 1 || gb != ga + 3) begin
            errors++;
            $display("FAIL tie_order got a=%0d b=%0d expected %0d %0d", ga, gb, s + 1, s + 4);
        end
        checks++;
        if (rda !== 8'h10 || ra != ga + 2) begin
            errors++;
            $display("FAIL tie_a_read got %h@%0d expected 10@%0d", rda, ra, ga + 2);
        end
        checks++;
        if (mem[5] !== 8'hAA) begin errors++; $display("FAIL tie_b_write got %h expected aa", mem[5]); end
        checks++;
        if (rb != -1) begin errors++; $display("FAIL tie_b_no_rvalid got %0d expected -1", rb); end
        run_pair(1, 0, 4'd5, 8'h00, 1, 0, 4'd6, 8'h00, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (ga < 0 || gb != ga + 3) begin
            errors++;
            $display("FAIL tie_alternate got a=%0d b=%0d expected b=a+3", ga, gb);
        end
        checks++;
        if (rda !== 8'hAA || rdb !== 8'h16) begin
            errors++;
            $display("FAIL tie2_data got a=%h b=%h expected aa 16", rda, rdb);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [3];
        int seq [$];
        int gc [$];
        int na;
        do_reset();
        for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd10; a_wdata = d[0];
        na = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_gnt) begin
                seq.push_back(0);
                gc.push_back(cyc);
                na++;
                if (na < 3) begin
                    a_addr  = 4'(10 + na);
                    a_wdata = d[na];
                end else begin
                    a_req = 1'b0;
                end
            end
            if (b_gnt) begin
                seq.push_back(1);
                gc.push_back(cyc);
                if (na >= 3) b_req = 1'b0;
            end
            if (seq.size() >= 6) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seq.size() != 6) begin
            errors++;
            $display("FAIL b2b_grant_count got %0d expected 6", seq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seq[i] != i % 2) begin
                    errors++;
                    $display("FAIL b2b_order idx=%0d got %0d expected %0d", i, seq[i], i % 2);
                end
                if (i > 0) begin
                    checks++;
                    if (gc[i] - gc[i-1] != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing idx=%0d got %0d expected 3", i, gc[i] - gc[i-1]);
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[10 + i] !== d[i]) begin
                errors++;
                $display("FAIL b2b_write addr=%0d got %h expected %h", 10 + i, mem[10 + i], d[i]);
            end
        end
        checks++;
        if (b_rdata !== 8'h11) begin errors++; $display("FAIL b2b_b_read got %h expected 11", b_rdata); end
    endtask

    task automatic test_reset_mid_access();
        logic [7:0] old9, rda, rdb;
        int got, nbad, ga, gb, ra, rb, nrv;
        do_reset();
        old9 = mem[9];
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_wdata = 8'h55;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_gnt) begin got = 1; break; end
        end
        rst_n = 1'b0;
        b_req = 1'b0;
        checks++;
        if (got != 1) begin errors++; $display("FAIL abort_b_gnt got %0d expected 1", got); end
        nbad = 0;
        repeat (3) begin
            @(negedge clk);
            if (b_gnt || b_rvalid || a_rvalid || mem_en) nbad++;
        end
        rst_n = 1'b1;
        checks++;
        if (nbad != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles expected 0", nbad); end
        checks++;
        if (mem[9] !== old9) begin errors++; $display("FAIL abort_no_write got %h expected %h", mem[9], old9); end
        run_pair(1, 0, 4'd9, 8'h00, 1, 0, 4'd3, 8'h00, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (ga < 0 || gb != ga + 3) begin
            errors++;
            $display("FAIL abort_a_first got a=%0d b=%0d expected b=a+3", ga, gb);
        end
        checks++;
        if (rda !== old9) begin errors++; $display("FAIL abort_readback got %h expected %h", rda, old9); end
    endtask

    task automatic test_drop_before_grant();
        logic [7:0] v;
        int got, na;
        do_reset();
        v = 8'($urandom);
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd13; b_wdata = v;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_gnt) begin got = 1; break; end
        end
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        @(negedge clk);
        a_req = 1'b0;
        na = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_gnt) na++;
        end
        checks++;
        if (got != 1 || na != 0) begin
            errors++;
            $display("FAIL drop_no_gnt got b_gnt=%0d a_gnts=%0d expected 1 0", got, na);
        end
        checks++;
        if (mem[13] !== v) begin errors++; $display("FAIL drop_b_write got %h expected %h", mem[13], v); end
    endtask

    task automatic test_raw();
        int ga, gb, ra, rb, nrv;
        logic [7:0] rda, rdb;
        do_reset();
        run_pair(1, 1, 4'd2, 8'h3C, 0, 0, 4'd0, 8'h00, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (ra != -1) begin errors++; $display("FAIL raw_write_no_rvalid got %0d expected -1", ra); end
        run_pair(1, 0, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00, ga, gb, ra, rb, rda, rdb, nrv);
        checks++;
        if (rda !== 8'h3C) begin errors++; $display("FAIL raw_data got %h expected 3c", rda); end
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] old7, rd_a, rd_b;
        int step, idle_n, gw, gb;
        bit brv;
        do_reset();
        arb_chk_on = 1'b0;
        old7 = mem[7];
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd7; a_lock = 1'b1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
        step = 0; idle_n = 0; gw = -1; gb = -1; brv = 1'b0; rd_a = '0; rd_b = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (b_gnt && gb < 0) begin gb = cyc; b_req = 1'b0; end
            if (b_rvalid) begin brv = 1'b1; rd_b = b_rdata; end
            case (step)
                0: if (a_gnt) begin a_req = 1'b0; step = 1; end
                1: if (a_rvalid) begin rd_a = a_rdata; step = 2; end
                2: begin
                    idle_n++;
                    if (idle_n == 3) begin
                        a_req = 1'b1; a_we = 1'b1; a_wdata = rd_a + 8'd1; a_lock = 1'b0;
                        step = 3;
                    end
                end
                3: if (a_gnt) begin a_req = 1'b0; gw = cyc; step = 4; end
                default: ;
            endcase
            if (brv) break;
        end
        a_req = 1'b0; b_req = 1'b0; a_lock = 1'b0;
        checks++;
        if (rd_a !== old7) begin errors++; $display("FAIL lock_read got %h expected %h", rd_a, old7); end
        checks++;
        if (gw < 0 || gb != gw + 3) begin
            errors++;
            $display("FAIL lock_b_after_write got b=%0d a_write=%0d expected b=a_write+3", gb, gw);
        end
        checks++;
        if (rd_b !== 8'(old7 + 8'd1) || mem[7] !== 8'(old7 + 8'd1)) begin
            errors++;
            $display("FAIL lock_rmw got b=%h mem=%h expected %h", rd_b, mem[7], 8'(old7 + 8'd1));
        end
    endtask
`endif

    task automatic drive_rand(input bit is_b, input int n);
        int gap;
        bit we, granted;
        logic [3:0] ad;
        logic [7:0] wd;
        for (int i = 0; i < n; i++) begin
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            ad = 4'($urandom);
            wd = 8'($urandom);
            if (is_b) begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
            else      begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
            granted = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (is_b ? b_gnt : a_gnt) begin granted = 1'b1; break; end
            end
            if (is_b) b_req = 1'b0;
            else      a_req = 1'b0;
            checks++;
            if (!granted) begin
                errors++;
                $display("FAIL rand_gnt_timeout req=%s txn=%0d", is_b ? "B" : "A", i);
            end else if (we) begin
                ref_mem[ad] = wd;
            end else if (is_b) begin
                exp_b.push_back(ref_mem[ad]);
            end else begin
                exp_a.push_back(ref_mem[ad]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        sb_on = 1'b1;
        fork
            drive_rand(1'b0, 40);
            drive_rand(1'b1, 40);
        join
        repeat (4) @(negedge clk);
        sb_on = 1'b0;
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL rand_missing_rvalid got pending a=%0d b=%0d expected 0 0", exp_a.size(), exp_b.size());
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mem[i] !== ref_mem[i]) begin
                errors++;
                $display("FAIL rand_mem addr=%0d got %h expected %h", i, mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_access();
        test_drop_before_grant();
        test_raw();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
